// File: rtl/alu_issue_arbiter_pkg.sv
// Shared types for the ALU issue arbiter: 64-bit data word, ALU instruction
// format and the flag bundle produced by the ALU.
// Build option: ALU_ARB_PER_PORT_CARRY_EN selects one carry flag per issue port
// instead of a single shared carry flag.
package alu_issue_arbiter_pkg;

  localparam int ALU_ARB_MAX_REQ = 4;

`ifdef ALU_ARB_PER_PORT_CARRY_EN
  localparam bit PER_PORT_CARRY = 1'b1;
`else
  localparam bit PER_PORT_CARRY = 1'b0;
`endif

  typedef logic [63:0] long_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SLL = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    long_t   a;
    long_t   b;
  } instruction_t;

  // z: zero, n: result bit 63, c: carry out (no-borrow for subtract),
  // sn: true sign of the signed result (n xor overflow)
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic sn;
  } flags_t;

endpackage

// File: rtl/alu.sv
// Shared combinational 64-bit ALU. Subtract is a + ~b + 1, so carry out
// means "no borrow"; SBC consumes the carry input the same way.
module alu
  import alu_issue_arbiter_pkg::*;
(
  input  instruction_t instr,
  input  logic         cin,
  output long_t        result,
  output flags_t       flags
);

  logic [64:0] sum;
  long_t       b_eff;
  logic        arith;
  logic        ovf;

  // Adder path, logic/shift path and flag generation
  always_comb begin
    sum    = '0;
    arith  = 1'b1;
    b_eff  = instr.b;
    result = '0;
    unique case (instr.op)
      OP_ADD: sum = {1'b0, instr.a} + {1'b0, instr.b};
      OP_ADC: sum = {1'b0, instr.a} + {1'b0, instr.b} + {64'd0, cin};
      OP_SUB: begin
        b_eff = ~instr.b;
        sum   = {1'b0, instr.a} + {1'b0, b_eff} + 65'd1;
      end
      OP_SBC: begin
        b_eff = ~instr.b;
        sum   = {1'b0, instr.a} + {1'b0, b_eff} + {64'd0, cin};
      end
      default: arith = 1'b0;
    endcase

    unique case (instr.op)
      OP_AND:  result = instr.a & instr.b;
      OP_OR:   result = instr.a | instr.b;
      OP_XOR:  result = instr.a ^ instr.b;
      OP_SLL:  result = instr.a << instr.b[5:0];
      default: result = sum[63:0];
    endcase

    ovf      = arith && (instr.a[63] == b_eff[63]) && (sum[63] != instr.a[63]);
    flags.z  = (result == '0);
    flags.n  = result[63];
    flags.c  = arith && sum[64];
    flags.sn = result[63] ^ ovf;
  end

endmodule

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// Generic round-robin arbiter. The search starts at the pointer; the pointer
// moves past the winner only when the grant is actually used (advance).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // First requester at or after the pointer, wrapping; lowest offset wins
  always_comb begin
    int j;
    j         = 0;
    grant_idx = ptr_q;
    grant_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant_idx = IW'(j);
        grant_any = 1'b1;
      end
    end
    grant = '0;
    if (enable && grant_any) grant[grant_idx] = 1'b1;
  end

  // Next pointer: one past the port that just transferred
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU between N_REQ issue ports with round-robin
// fairness, buffers one result (tagged with the issuing port) for writeback,
// and owns the architectural carry flag.
// Build option: ALU_ARB_PER_PORT_CARRY_EN makes carry_q one bit per port.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  instruction_t [N_REQ-1:0]               req_instr,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [ID_W-1:0]                        rsp_id,
  output long_t                                  rsp_result,
  output logic                                   rsp_z,
  output logic                                   rsp_n,
  output logic                                   rsp_c,
  output logic                                   rsp_sn,
  input  logic                                   carry_clr,
  output logic [(PER_PORT_CARRY ? N_REQ : 1)-1:0] carry_q
);

  localparam int CW = PER_PORT_CARRY ? N_REQ : 1;

  if (N_REQ < 2 || N_REQ > ALU_ARB_MAX_REQ) begin : g_bad_n_req
    $error("alu_issue_arbiter: N_REQ out of range");
  end

  logic            can_accept;
  logic            xfer;
  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic            alu_cin;
  instruction_t    alu_instr;
  long_t           alu_result;
  flags_t          alu_flags;

  logic            rsp_valid_q,  rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q,     rsp_id_d;
  long_t           rsp_result_q, rsp_result_d;
  flags_t          rsp_flags_q,  rsp_flags_d;
  logic [CW-1:0]   carry_d;

  // Buffer can take a new result if empty or being drained this cycle.
  // Grants are held off while reset is asserted so no partial grant escapes.
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign xfer       = grant_any && can_accept && !rst;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .enable    (can_accept && !rst),
    .advance   (xfer),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign alu_instr = req_instr[grant_idx];

`ifdef ALU_ARB_PER_PORT_CARRY_EN
  assign alu_cin = carry_q[grant_idx];
`else
  assign alu_cin = carry_q[0];
`endif

  alu u_alu (
    .instr  (alu_instr),
    .cin    (alu_cin),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Output buffer: load on transfer, otherwise empty on drain; data holds
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_idx;
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Carry update; an explicit clear beats a same-cycle transfer
  always_comb begin
    carry_d = carry_q;
    if (carry_clr) begin
      carry_d = '0;
    end else if (xfer) begin
`ifdef ALU_ARB_PER_PORT_CARRY_EN
      carry_d[grant_idx] = alu_flags.c;
`else
      carry_d[0] = alu_flags.c;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      carry_q      <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      carry_q      <= carry_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_z      = rsp_flags_q.z;
  assign rsp_n      = rsp_flags_q.n;
  assign rsp_c      = rsp_flags_q.c;
  assign rsp_sn     = rsp_flags_q.sn;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 1;
  localparam int CW  = PER_PORT_CARRY ? N : 1;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  instruction_t [N-1:0]  req_instr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  long_t                 rsp_result;
  logic                  rsp_z, rsp_n, rsp_c, rsp_sn;
  logic                  carry_clr;
  logic [CW-1:0]         carry_q;

  alu_issue_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_instr  (req_instr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .rsp_c      (rsp_c),
    .rsp_sn     (rsp_sn),
    .carry_clr  (carry_clr),
    .carry_q    (carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit            m_valid;
  int            m_id;
  long_t         m_res;
  logic [3:0]    m_flg;
  int            m_ptr;
  logic [CW-1:0] m_car;
  logic [N-1:0]  held;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ALU reference from arithmetic definitions; flags returned as {z,n,c,sn}
  function automatic void alu_ref(input instruction_t ins, input logic cin,
                                  output long_t r, output logic [3:0] f);
    logic signed [66:0] sa, sb, t;
    logic [64:0] ua, ub;
    logic c, sn;
    sa = $signed({{3{ins.a[63]}}, ins.a});
    sb = $signed({{3{ins.b[63]}}, ins.b});
    ua = {1'b0, ins.a};
    ub = {1'b0, ins.b};
    c  = 1'b0;
    case (ins.op)
      OP_ADD: begin r = ins.a + ins.b; c = (r < ins.a); t = sa + sb; sn = t[66]; end
      OP_ADC: begin
        r = ins.a + ins.b + {63'd0, cin};
        c = ((ua + ub + {64'd0, cin}) > 65'h0_FFFF_FFFF_FFFF_FFFF);
        t = sa + sb + $signed({66'd0, cin}); sn = t[66];
      end
      OP_SUB: begin r = ins.a - ins.b; c = (ins.a >= ins.b); t = sa - sb; sn = t[66]; end
      OP_SBC: begin
        r = ins.a - ins.b - {63'd0, !cin};
        c = (ua >= ub + {64'd0, !cin});
        t = sa - sb - $signed({66'd0, !cin}); sn = t[66];
      end
      OP_AND: begin r = ins.a & ins.b; sn = r[63]; end
      OP_OR:  begin r = ins.a | ins.b; sn = r[63]; end
      OP_XOR: begin r = ins.a ^ ins.b; sn = r[63]; end
      default: begin r = ins.a << ins.b[5:0]; sn = r[63]; end
    endcase
    f = {(r == 64'd0), r[63], c, sn};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_res = '0; m_flg = '0; m_ptr = 0; m_car = '0; held = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check_val({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(m_valid));
    check_val({pfx, "_rsp_id"}, 64'(rsp_id), 64'(m_id));
    check_val({pfx, "_rsp_result"}, rsp_result, m_res);
    check_val({pfx, "_rsp_flags"}, 64'({rsp_z, rsp_n, rsp_c, rsp_sn}), 64'(m_flg));
    check_val({pfx, "_carry_q"}, 64'(carry_q), 64'(m_car));
  endtask

  // One clock: called at a falling edge with inputs already applied
  task automatic cycle();
    int g;
    logic can, go, cin, c_new;
    logic [N-1:0] er;
    long_t r;
    logic [3:0] f;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int p;
      p = (m_ptr + i) % N;
      if (g < 0 && req_valid[p]) g = p;
    end
    can = !m_valid || rsp_ready;
    go  = (g >= 0) && can;
    er  = '0;
    r   = '0;
    f   = '0;
    if (go) begin
      er[g] = 1'b1;
`ifdef ALU_ARB_PER_PORT_CARRY_EN
      cin = m_car[g];
`else
      cin = m_car[0];
`endif
      alu_ref(req_instr[g], cin, r, f);
    end
    check_val("req_ready", 64'(req_ready), 64'(er));
    held = req_valid & ~er;
    @(posedge clk);
    c_new = f[1];
    if (go) begin
      m_valid = 1; m_id = g; m_res = r; m_flg = f; m_ptr = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    if (carry_clr) m_car = '0;
    else if (go) begin
`ifdef ALU_ARB_PER_PORT_CARRY_EN
      m_car[g] = c_new;
`else
      m_car[0] = c_new;
`endif
    end
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic set_req(input int p, input alu_op_e op, input long_t a, input long_t b);
    req_instr[p].op = op;
    req_instr[p].a  = a;
    req_instr[p].b  = b;
  endtask

  function automatic long_t rand_operand();
    case ($urandom_range(0, 3))
      0: return 64'd0;
      1: return '1;
      2: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; carry_clr = 1'b0;
    req_valid = '1;
    set_req(0, OP_ADD, 64'd5, 64'd6);
    set_req(1, OP_ADD, 64'd7, 64'd8);
    model_reset();
    #3;
    check_outputs("reset");
    check_val("reset_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;

    // carry chain on port 0
    req_valid = 2'b01;
    set_req(0, OP_ADD, '1, 64'd1);
    cycle();
    check_val("chain_result", rsp_result, 64'd0);
    check_val("chain_c", 64'(rsp_c), 64'd1);
    check_val("chain_z", 64'(rsp_z), 64'd1);
    check_val("chain_carry_q", 64'(carry_q), 64'd1);
    set_req(0, OP_ADC, 64'd0, 64'd0);
    cycle();
    check_val("adc_result", rsp_result, 64'd1);

    // clear wins over the carry produced by a same-cycle transfer
    set_req(0, OP_ADD, '1, 64'd1);
    carry_clr = 1'b1;
    cycle();
    carry_clr = 1'b0;
    check_val("clr_rsp_c", 64'(rsp_c), 64'd1);
    check_val("clr_carry_q", 64'(carry_q), 64'd0);

`ifdef ALU_ARB_PER_PORT_CARRY_EN
    req_valid = 2'b10;
    set_req(1, OP_ADD, '1, 64'd1);
    cycle();
    req_valid = 2'b01;
    set_req(0, OP_ADC, 64'd0, 64'd0);
    cycle();
    check_val("pp_result", rsp_result, 64'd0);
    check_val("pp_carry_q", 64'(carry_q), 64'd2);
`endif

    // fairness: both ports always valid, writeback always ready
    req_valid = 2'b11;
    set_req(0, OP_ADD, 64'd0, 64'd1);
    set_req(1, OP_ADD, 64'd1, 64'd1);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_val("fair_result", rsp_result, 64'(m_id + 1));
    end

    // backpressure: full buffer, writeback stalls for three cycles
    rsp_ready = 1'b0;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    check_val("bp_release_valid", 64'(rsp_valid), 64'd1);

    // reset in the middle of traffic with a result buffered
    check_val("pre_rst_valid", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("midrst");
    check_val("midrst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check_val("post_rst_id", 64'(rsp_id), 64'd0);

    // random traffic respecting the hold-while-not-accepted rule
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < N; p++) begin
        if (!held[p]) begin
          req_valid[p]    = ($urandom_range(0, 3) != 0);
          req_instr[p].op = alu_op_e'($urandom_range(0, 7));
          req_instr[p].a  = rand_operand();
          req_instr[p].b  = rand_operand();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      carry_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
